// File: rtl/noc_traffic_node.sv
`default_nettype none
// ============================================================================
//  Module      : noc_traffic_node
//  Description : NoC endpoint traffic generator and checker. Injects a
//                configurable stream of fixed-length packets towards one
//                destination and checks every packet it receives.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_traffic_node #(
    parameter int NOC_DATA_WIDTH = 32,
    parameter int COORD_W        = 4,
    parameter int X_ID           = 0,
    parameter int Y_ID           = 0,
    parameter int DEST_X_ID      = 1,
    parameter int DEST_Y_ID      = 1,
    parameter int PKT_LEN        = 4,
    parameter int NUM_PKTS       = 16,
    parameter int INJ_GAP        = 2
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic                      start,
    input  logic                      rx_throttle,
    input  logic                      receive_valid,
    output logic                      receive_ready,
    input  logic [NOC_DATA_WIDTH-1:0] receive_flit,
    input  logic                      receive_is_header,
    input  logic                      receive_is_tail,
    output logic                      sender_valid,
    input  logic                      sender_ready,
    output logic [NOC_DATA_WIDTH-1:0] sender_flit,
    output logic                      sender_is_header,
    output logic                      sender_is_tail,
    output logic [15:0]               sent_num,
    output logic [15:0]               receive_num,
    output logic [15:0]               err_num,
    output logic                      done
);

    // TX state encoding
    localparam logic [2:0] c_tx_idle = 3'd0;
    localparam logic [2:0] c_tx_hdr  = 3'd1;
    localparam logic [2:0] c_tx_body = 3'd2;
    localparam logic [2:0] c_tx_gap  = 3'd3;
    localparam logic [2:0] c_tx_done = 3'd4;

    // RX state encoding
    localparam logic [0:0] c_rx_wait_hdr = 1'b0;
    localparam logic [0:0] c_rx_body     = 1'b1;

    localparam logic [COORD_W-1:0] c_x_id      = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] c_y_id      = COORD_W'(Y_ID);
    localparam logic [COORD_W-1:0] c_dest_x    = COORD_W'(DEST_X_ID);
    localparam logic [COORD_W-1:0] c_dest_y    = COORD_W'(DEST_Y_ID);
    localparam logic [7:0]         c_last_idx  = 8'(PKT_LEN - 1);
    localparam logic [15:0]        c_gap_last  = 16'(INJ_GAP - 1);
    localparam logic [16:0]        c_num_pkts  = 17'(NUM_PKTS);
    localparam bit                 c_endless   = (NUM_PKTS == 0);
    localparam bit                 c_no_gap    = (INJ_GAP == 0);

    // Header flit: dest Y/X, own Y/X, then the 16-bit sequence number
    function automatic logic [NOC_DATA_WIDTH-1:0] f_header(input logic [15:0] seq);
        logic [NOC_DATA_WIDTH-1:0] v;
        v = '0;
        v[COORD_W-1:0]             = c_dest_y;
        v[2*COORD_W-1:COORD_W]     = c_dest_x;
        v[3*COORD_W-1:2*COORD_W]   = c_y_id;
        v[4*COORD_W-1:3*COORD_W]   = c_x_id;
        v[4*COORD_W+15:4*COORD_W]  = seq;
        return v;
    endfunction

    // Body flit: zero-extended {seq, flit index}
    function automatic logic [NOC_DATA_WIDTH-1:0] f_body(input logic [15:0] seq,
                                                         input logic [7:0]  idx);
        logic [NOC_DATA_WIDTH-1:0] v;
        v = '0;
        v[23:0] = {seq, idx};
        return v;
    endfunction

    // ------------------------------------------------------------------ TX
    logic [2:0]                r_tx_state;
    logic [15:0]               r_seq;
    logic [7:0]                r_tx_idx;
    logic [15:0]               r_gap_cnt;
    logic [15:0]               r_sent_num;
    logic                      r_done;
    logic                      r_tx_valid;
    logic [NOC_DATA_WIDTH-1:0] r_tx_flit;
    logic                      r_tx_hdr;
    logic                      r_tx_tail;
    logic                      w_tx_xfer;
    logic                      w_last_pkt;

    assign w_tx_xfer  = r_tx_valid & sender_ready;
    assign w_last_pkt = !c_endless && (({1'b0, r_sent_num} + 17'd1) == c_num_pkts);

    // TX sequencer: flit and flags are registered and held until accepted
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_tx_state <= c_tx_idle;
            r_seq      <= '0;
            r_tx_idx   <= '0;
            r_gap_cnt  <= '0;
            r_sent_num <= '0;
            r_done     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_flit  <= '0;
            r_tx_hdr   <= 1'b0;
            r_tx_tail  <= 1'b0;
        end else begin
            case (r_tx_state)
                c_tx_idle: begin
                    if (start) begin
                        r_tx_valid <= 1'b1;
                        r_tx_flit  <= f_header(r_seq);
                        r_tx_hdr   <= 1'b1;
                        r_tx_tail  <= 1'b0;
                        r_tx_state <= c_tx_hdr;
                    end
                end
                c_tx_hdr: begin
                    if (w_tx_xfer) begin
                        r_tx_flit  <= f_body(r_seq, 8'd1);
                        r_tx_hdr   <= 1'b0;
                        r_tx_tail  <= (c_last_idx == 8'd1);
                        r_tx_idx   <= 8'd1;
                        r_tx_state <= c_tx_body;
                    end
                end
                c_tx_body: begin
                    if (w_tx_xfer) begin
                        if (r_tx_tail) begin
                            r_seq     <= r_seq + 16'd1;
                            r_tx_tail <= 1'b0;
                            if (r_sent_num != 16'hFFFF) begin
                                r_sent_num <= r_sent_num + 16'd1;
                            end
                            if (w_last_pkt) begin
                                r_tx_valid <= 1'b0;
                                r_done     <= 1'b1;
                                r_tx_state <= c_tx_done;
                            end else if (c_no_gap) begin
                                r_tx_flit  <= f_header(r_seq + 16'd1);
                                r_tx_hdr   <= 1'b1;
                                r_tx_state <= c_tx_hdr;
                            end else begin
                                r_tx_valid <= 1'b0;
                                r_gap_cnt  <= '0;
                                r_tx_state <= c_tx_gap;
                            end
                        end else begin
                            r_tx_idx  <= r_tx_idx + 8'd1;
                            r_tx_flit <= f_body(r_seq, r_tx_idx + 8'd1);
                            r_tx_tail <= ((r_tx_idx + 8'd1) == c_last_idx);
                        end
                    end
                end
                c_tx_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_tx_valid <= 1'b1;
                        r_tx_flit  <= f_header(r_seq);
                        r_tx_hdr   <= 1'b1;
                        r_tx_state <= c_tx_hdr;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                c_tx_done: begin
                    r_tx_state <= c_tx_done;
                end
                default: begin
                    r_tx_state <= c_tx_idle;
                end
            endcase
        end
    end

    assign sender_valid     = r_tx_valid;
    assign sender_flit      = r_tx_flit;
    assign sender_is_header = r_tx_hdr;
    assign sender_is_tail   = r_tx_tail;
    assign sent_num         = r_sent_num;
    assign done             = r_done;

    // ------------------------------------------------------------------ RX
    logic [0:0]  r_rx_state;
    logic        r_rx_ready;
    logic [15:0] r_rx_seq;
    logic [7:0]  r_rx_idx;
    logic        r_rx_bad;
    logic [15:0] r_recv_num;
    logic [15:0] r_err_num;
    logic        w_rx_xfer;
    logic        w_hdr_dest_bad;
    logic [15:0] w_hdr_seq;
    logic        w_body_bad;
    logic [15:0] w_err_inc;
    logic [15:0] w_recv_inc;

    assign w_rx_xfer      = receive_valid & r_rx_ready;
    assign w_hdr_dest_bad = (receive_flit[COORD_W-1:0] != c_y_id) ||
                            (receive_flit[2*COORD_W-1:COORD_W] != c_x_id);
    assign w_hdr_seq      = receive_flit[4*COORD_W+15:4*COORD_W];
    assign w_body_bad     = (receive_flit != f_body(r_rx_seq, r_rx_idx)) ||
                            (receive_is_tail != (r_rx_idx == c_last_idx));
    assign w_err_inc      = (r_err_num  == 16'hFFFF) ? r_err_num  : r_err_num  + 16'd1;
    assign w_recv_inc     = (r_recv_num == 16'hFFFF) ? r_recv_num : r_recv_num + 16'd1;

    // Receive-ready: steady high, or alternating when backpressure is requested
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_rx_ready <= 1'b1;
        end else if (rx_throttle) begin
            r_rx_ready <= ~r_rx_ready;
        end else begin
            r_rx_ready <= 1'b1;
        end
    end

    // RX checker: tracks one packet at a time and tallies good/bad packets
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_rx_state <= c_rx_wait_hdr;
            r_rx_seq   <= '0;
            r_rx_idx   <= '0;
            r_rx_bad   <= 1'b0;
            r_recv_num <= '0;
            r_err_num  <= '0;
        end else if (w_rx_xfer) begin
            if (receive_is_header) begin
                // A header while mid-packet means the previous packet was truncated
                if (r_rx_state == c_rx_body) begin
                    r_err_num <= w_err_inc;
                end
                r_rx_seq   <= w_hdr_seq;
                r_rx_bad   <= w_hdr_dest_bad;
                r_rx_idx   <= 8'd1;
                r_rx_state <= c_rx_body;
            end else if (r_rx_state == c_rx_wait_hdr) begin
                r_err_num <= w_err_inc;
            end else if (receive_is_tail) begin
                if (r_rx_bad || w_body_bad) begin
                    r_err_num <= w_err_inc;
                end else begin
                    r_recv_num <= w_recv_inc;
                end
                r_rx_bad   <= 1'b0;
                r_rx_state <= c_rx_wait_hdr;
            end else begin
                r_rx_bad <= r_rx_bad | w_body_bad;
                r_rx_idx <= r_rx_idx + 8'd1;
            end
        end
    end

    assign receive_ready = r_rx_ready;
    assign receive_num   = r_recv_num;
    assign err_num       = r_err_num;

endmodule
`default_nettype wire
